vga_bounce_pic: RTL and testbench

- Pixel-source stage directly upstream of the VGA timing controller. Consumes the controller's pix_x/pix_y and returns pix_data with zero latency.
- Draws a solid square on a fixed background colour. The square moves diagonally, bounces off the active-area edges, and changes colour on every bounce.
- Square position updates once per frame, during blanking, so a visible frame never tears.

---
 rtl/vga_pkg.sv | 37 +++
 rtl/vga_bounce_axis.sv | 51 +++++
 rtl/vga_bounce_pic.sv | 115 +++++++++++
 tb/tb_vga_bounce_pic.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: active-area timing, RGB colours,
// bounce direction encoding.
package vga_pkg;

  localparam int H_VALID = 800;
  localparam int V_VALID = 600;

  typedef logic [2:0] rgb_t;

  localparam rgb_t BLACK   = 3'b000;
  localparam rgb_t BLUE    = 3'b001;
  localparam rgb_t GREEN   = 3'b010;
  localparam rgb_t CYAN    = 3'b011;
  localparam rgb_t RED     = 3'b100;
  localparam rgb_t MAGENTA = 3'b101;
  localparam rgb_t YELLOW  = 3'b110;
  localparam rgb_t WHITE   = 3'b111;

  // {dx,dy}: dx=1 moves left, dy=1 moves up
  typedef enum logic [1:0] {
    DR_DN = 2'b00,
    DR_UP = 2'b01,
    DL_DN = 2'b10,
    DL_UP = 2'b11
  } dir_e;

  function automatic rgb_t next_color(
    input rgb_t c,
    input rgb_t bg
  );
    rgb_t n;
    n = c + 3'd1;
    if (n == bg) n = n + 3'd1;
    return n;
  endfunction

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of the bouncing square: position register
// with clamp-at-edge and bounce detection.
module vga_bounce_axis #(
  parameter int LIMIT = 800,
  parameter int SIZE  = 64,
  parameter int STEP  = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rstn,
  input  logic        move_en,
  input  logic        dir,
  output logic [10:0] pos,
  output logic        bounce
);

  localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);
  localparam logic [10:0] STP     = 11'(STEP);

  logic [10:0] pos_q, pos_d;

  always_comb begin
    pos_d  = pos_q;
    bounce = 1'b0;
    if (move_en) begin
      if (!dir) begin
        if (pos_q + STP >= MAX_POS) begin
          pos_d  = MAX_POS;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q + STP;
        end
      end else begin
        // test before subtracting so the step never wraps
        if (pos_q <= STP) begin
          pos_d  = '0;
          bounce = 1'b1;
        end else begin
          pos_d = pos_q - STP;
        end
      end
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rstn) begin
    if (!sys_rstn) pos_q <= '0;
    else           pos_q <= pos_d;
  end

  assign pos = pos_q;

endmodule

// File: rtl/vga_bounce_pic.sv
// Bouncing-square pixel source: zero-latency pix_data,
// motion stepped once per frame during blanking.
module vga_bounce_pic
  import vga_pkg::*;
#(
  parameter int   H_VALID   = vga_pkg::H_VALID,
  parameter int   V_VALID   = vga_pkg::V_VALID,
  parameter int   BOX_SIZE  = 64,
  parameter int   STEP      = 2,
  parameter int   FRAME_DIV = 1,
  parameter rgb_t BG_COLOR  = BLUE
) (
  input  logic        vga_clk,
  input  logic        sys_rstn,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        pause,
  output logic [2:0]  pix_data,
  output logic        frame_tick,
  output logic [7:0]  bounce_cnt
);

  localparam logic [10:0] X_LAST   = 11'(H_VALID - 1);
  localparam logic [10:0] Y_LAST   = 11'(V_VALID - 1);
  localparam logic [10:0] BOX      = 11'(BOX_SIZE);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

  logic        frame_end;
  logic        frame_tick_q, frame_tick_d;
  logic [7:0]  div_q, div_d;
  rgb_t        color_q, color_d;
  logic [7:0]  cnt_q, cnt_d;
  dir_e        dir_q, dir_d;
  logic        move_en;
  logic        x_bnc, y_bnc, bnc;
  logic [10:0] box_x, box_y;
  logic        in_box;

  assign frame_end = (pix_x == X_LAST) && (pix_y == Y_LAST);
  assign move_en   = frame_tick_q && !pause && (div_q == DIV_LAST);
  assign bnc       = x_bnc || y_bnc;

  vga_bounce_axis #(
    .LIMIT (H_VALID),
    .SIZE  (BOX_SIZE),
    .STEP  (STEP)
  ) u_x (
    .vga_clk  (vga_clk),
    .sys_rstn (sys_rstn),
    .move_en  (move_en),
    .dir      (dir_q[1]),
    .pos      (box_x),
    .bounce   (x_bnc)
  );

  vga_bounce_axis #(
    .LIMIT (V_VALID),
    .SIZE  (BOX_SIZE),
    .STEP  (STEP)
  ) u_y (
    .vga_clk  (vga_clk),
    .sys_rstn (sys_rstn),
    .move_en  (move_en),
    .dir      (dir_q[0]),
    .pos      (box_y),
    .bounce   (y_bnc)
  );

  always_comb begin
    frame_tick_d = frame_end;
    div_d        = div_q;
    color_d      = color_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    if (frame_tick_q && !pause) begin
      div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
    end
    if (bnc) begin
      color_d = next_color(color_q, BG_COLOR);
      if (cnt_q != 8'hff) cnt_d = cnt_q + 8'd1;
    end
    // each axis flips only on its own bounce
    unique case (dir_q)
      DR_DN: dir_d = dir_e'({ x_bnc,  y_bnc});
      DR_UP: dir_d = dir_e'({ x_bnc, ~y_bnc});
      DL_DN: dir_d = dir_e'({~x_bnc,  y_bnc});
      DL_UP: dir_d = dir_e'({~x_bnc, ~y_bnc});
      default: dir_d = DR_DN;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      frame_tick_q <= 1'b0;
      div_q        <= '0;
      color_q      <= WHITE;
      cnt_q        <= '0;
      dir_q        <= DR_DN;
    end else begin
      frame_tick_q <= frame_tick_d;
      div_q        <= div_d;
      color_q      <= color_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
    end
  end

  assign in_box = (pix_x >= box_x) && (pix_x < box_x + BOX)
               && (pix_y >= box_y) && (pix_y < box_y + BOX);

  assign pix_data   = in_box ? color_q : BG_COLOR;
  assign frame_tick = frame_tick_q;
  assign bounce_cnt = cnt_q;

endmodule

// File: tb/tb_vga_bounce_pic.sv
// Bench for vga_bounce_pic: three parameterisations driven
// with short synthetic frames, checked against a geometric model.
module tb_vga_bounce_pic;

  logic        clk;
  logic        rst_n;
  logic        pause;
  logic [10:0] px [3];
  logic [10:0] py [3];
  logic [2:0]  pd [3];
  logic        ft [3];
  logic [7:0]  bc [3];

  int n_pass;
  int n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vga_bounce_pic u_d0 (
    .vga_clk    (clk),
    .sys_rstn   (rst_n),
    .pix_x      (px[0]),
    .pix_y      (py[0]),
    .pause      (pause),
    .pix_data   (pd[0]),
    .frame_tick (ft[0]),
    .bounce_cnt (bc[0])
  );

  vga_bounce_pic #(.FRAME_DIV(2)) u_d1 (
    .vga_clk    (clk),
    .sys_rstn   (rst_n),
    .pix_x      (px[1]),
    .pix_y      (py[1]),
    .pause      (pause),
    .pix_data   (pd[1]),
    .frame_tick (ft[1]),
    .bounce_cnt (bc[1])
  );

  vga_bounce_pic #(
    .H_VALID(16), .V_VALID(12), .BOX_SIZE(4), .STEP(3)
  ) u_d2 (
    .vga_clk    (clk),
    .sys_rstn   (rst_n),
    .pix_x      (px[2]),
    .pix_y      (py[2]),
    .pause      (pause),
    .pix_data   (pd[2]),
    .frame_tick (ft[2]),
    .bounce_cnt (bc[2])
  );

  // model: position plus signed velocity per axis
  typedef struct {
    int h, v, b, s, fd, bg;
    int x, y, vx, vy, col, cnt, div;
  } mdl_t;

  mdl_t m [3];

  typedef struct {
    int px, py, pd;
  } vec_t;

  vec_t vecs [8];

  function automatic mdl_t m_reset(input mdl_t a);
    a.x = 0;  a.y = 0;
    a.vx = a.s; a.vy = a.s;
    a.col = 7; a.cnt = 0; a.div = 0;
    return a;
  endfunction

  function automatic void step_axis(
    inout int p, inout int vel, input int lim,
    input int b, input int s, output bit hit
  );
    hit = 0;
    if (vel > 0) begin
      if (p + s >= lim - b) begin
        p = lim - b; vel = -s; hit = 1;
      end else p = p + s;
    end else begin
      if (p - s <= 0) begin
        p = 0; vel = s; hit = 1;
      end else p = p - s;
    end
  endfunction

  function automatic mdl_t m_tick(input mdl_t a, input bit p);
    bit hx, hy;
    if (p) return a;
    if (a.div < a.fd - 1) begin
      a.div++;
      return a;
    end
    a.div = 0;
    step_axis(a.x, a.vx, a.h, a.b, a.s, hx);
    step_axis(a.y, a.vy, a.v, a.b, a.s, hy);
    if (hx || hy) begin
      a.col = (a.col + 1) % 8;
      if (a.col == a.bg) a.col = (a.col + 1) % 8;
      if (a.cnt < 255) a.cnt++;
    end
    return a;
  endfunction

  function automatic int exp_pix(input mdl_t a, input int x, input int y);
    if (x >= a.x && x < a.x + a.b && y >= a.y && y < a.y + a.b)
      return a.col;
    return a.bg;
  endfunction

  // probe points around the square edges plus one random pixel
  function automatic void probe(
    input mdl_t a, input int k, output int x, output int y
  );
    x = a.x; y = a.y;
    case (k)
      1: x = a.x + a.b - 1;
      2: y = a.y + a.b - 1;
      3: x = (a.x + a.b < a.h) ? a.x + a.b : a.x - 1;
      4: y = (a.y + a.b < a.v) ? a.y + a.b : a.y - 1;
      5: begin
        x = $urandom_range(0, a.h - 2);
        y = $urandom_range(0, a.v - 1);
      end
      default: ;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic set_zero();
    for (int i = 0; i < 3; i++) begin
      px[i] = '0; py[i] = '0;
    end
  endtask

  task automatic probe_all(input int fr);
    int x, y;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        probe(m[i], k, x, y);
        px[i] = 11'(x); py[i] = 11'(y);
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        probe(m[i], 0, x, y);
        chk($sformatf("pix d%0d f%0d k%0d (%0d,%0d)",
             i, fr, k, px[i], py[i]),
            pd[i], exp_pix(m[i], px[i], py[i]));
      end
    end
  endtask

  task automatic do_frame(input bit p, input int fr);
    pause = p;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      px[i] = 11'(m[i].h - 1); py[i] = 11'(m[i].v - 1);
    end
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("ft_pre d%0d", i), ft[i], 0);
    @(negedge clk);
    set_zero();
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("ft_pulse d%0d", i), ft[i], 1);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      m[i] = m_tick(m[i], p);
      chk($sformatf("ft_post d%0d", i), ft[i], 0);
      chk($sformatf("bounce_cnt d%0d f%0d", i, fr), bc[i], m[i].cnt);
    end
    probe_all(fr);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    pause = 1'b0;
    rst_n = 1'b0;
    set_zero();
    m[0] = '{h:800, v:600, b:64, s:2, fd:1, bg:1, default:0};
    m[1] = '{h:800, v:600, b:64, s:2, fd:2, bg:1, default:0};
    m[2] = '{h:16,  v:12,  b:4,  s:3, fd:1, bg:1, default:0};
    for (int i = 0; i < 3; i++) m[i] = m_reset(m[i]);

    vecs[0] = '{0,   0,   7};
    vecs[1] = '{63,  63,  7};
    vecs[2] = '{64,  0,   1};
    vecs[3] = '{0,   64,  1};
    vecs[4] = '{63,  0,   7};
    vecs[5] = '{0,   63,  7};
    vecs[6] = '{64,  64,  1};
    vecs[7] = '{400, 300, 1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst ft d%0d", i), ft[i], 0);
      chk($sformatf("rst cnt d%0d", i), bc[i], 0);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      px[0] = 11'(vecs[i].px); py[0] = 11'(vecs[i].py);
      #1;
      chk($sformatf("vec%0d (%0d,%0d)", i, vecs[i].px, vecs[i].py),
          pd[0], vecs[i].pd);
    end
    // a few raster pixels must not raise frame_tick
    for (int x = 795; x < 800; x++) begin
      @(negedge clk);
      px[0] = 11'(x); py[0] = 11'd598;
      #1;
      chk("raster ft", ft[0], 0);
    end
    set_zero();

    do_frame(1'b0, 0);
    @(negedge clk);
    px[0] = 11'd2; py[0] = 11'd2; #1;
    chk("moved (2,2)", pd[0], 7);
    @(negedge clk);
    px[0] = 11'd1; py[0] = 11'd2; #1;
    chk("moved (1,2)", pd[0], 1);
    @(negedge clk);
    px[0] = 11'd65; py[0] = 11'd65; #1;
    chk("moved (65,65)", pd[0], 7);

    for (int f = 1; f < 4; f++) do_frame(1'b1, f);
    for (int f = 4; f < 904; f++) do_frame($urandom_range(0, 3) == 0, f);

    chk("bounce_sat d2", bc[2], 255);

    // reset asynchronously while frame_tick is high
    pause = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      px[i] = 11'(m[i].h - 1); py[i] = 11'(m[i].v - 1);
    end
    @(negedge clk);
    set_zero();
    #1;
    chk("pre_rst ft", ft[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m[i] = m_reset(m[i]);
      chk($sformatf("async ft d%0d", i), ft[i], 0);
      chk($sformatf("async cnt d%0d", i), bc[i], 0);
    end
    px[0] = 11'd63; py[0] = 11'd63; #1;
    chk("async pix in", pd[0], 7);
    px[0] = 11'd64; py[0] = 11'd0; #1;
    chk("async pix out", pd[0], 1);
    set_zero();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst ft", ft[0], 0);
    do_frame(1'b0, 9000);
    do_frame(1'b0, 9001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
